instr_fetch_unit: RTL

//  Front end of the RV32IM core: owns the PC and issues word fetches to instruction memory.

---
 rtl/instr_fetch_unit_if.sv | 28 ++
 rtl/instr_fetch_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Signal bundle of the fetch unit: execute redirect, instruction-memory bus and decode handshake.
// The fetch unit connects through the master modport; the environment uses the slave modport.
interface instr_fetch_unit_if;
  logic        ip_redirect;
  logic [31:0] ip_redirect_addr;
  logic        op_imem_req;
  logic [31:0] op_imem_addr;
  logic        ip_imem_gnt;
  logic        ip_imem_rvalid;
  logic [31:0] ip_imem_rdata;
  logic        op_instr_valid;
  logic        ip_instr_ready;
  logic [31:0] op_instr;
  logic [31:0] op_instr_pc;
  logic        op_misaligned;

  modport master (
    input  ip_redirect, ip_redirect_addr, ip_imem_gnt, ip_imem_rvalid, ip_imem_rdata,
           ip_instr_ready,
    output op_imem_req, op_imem_addr, op_instr_valid, op_instr, op_instr_pc, op_misaligned
  );

  modport slave (
    output ip_redirect, ip_redirect_addr, ip_imem_gnt, ip_imem_rvalid, ip_imem_rdata,
           ip_instr_ready,
    input  op_imem_req, op_imem_addr, op_instr_valid, op_instr, op_instr_pc, op_misaligned
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// RV32 instruction fetch front end: owns the PC, issues word fetches, buffers responses in an
// in-order FIFO for decode and redirects on execute's branch decisions, dropping wrong-path data.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                ip_clk,
  input logic                ip_rst_n,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DISCARD = 2'd1,
    ST_HALT    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             run_q;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] disc_q, disc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W-1:0] tw_q, tw_d, tr_q, tr_d;

  logic [31:0] instr_mem [FIFO_DEPTH];
  logic [31:0] ipc_mem   [FIFO_DEPTH];
  logic [31:0] tag_mem   [FIFO_DEPTH];

  logic req, misaligned, room, head_vld;
  logic issue, resp, stale, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Requests in flight plus buffered entries never exceed the FIFO, so a response always fits.
  assign room     = ({1'b0, out_q} + {1'b0, cnt_q}) < SUM_W'(FIFO_DEPTH);
  assign head_vld = (cnt_q != '0);
  assign issue    = req & bus.ip_imem_gnt;
  assign resp     = bus.ip_imem_rvalid & (out_q != '0);
  assign stale    = bus.ip_redirect | (disc_q != '0);
  assign push     = resp & ~stale;
  assign pop      = bus.op_instr_valid & bus.ip_instr_ready;

  always_comb begin
    out_d = out_q + CNT_W'(issue) - CNT_W'(resp);

    pc_d = pc_q;
    if (bus.ip_redirect)
      pc_d = bus.ip_redirect_addr;
    else if (issue)
      pc_d = pc_q + 32'd4;

    // Everything still in flight after a redirect edge belongs to the wrong path.
    disc_d = disc_q;
    if (bus.ip_redirect)
      disc_d = out_d;
    else if (resp && (disc_q != '0))
      disc_d = disc_q - CNT_W'(1);

    wr_d  = push ? ptr_inc(wr_q) : wr_q;
    rd_d  = bus.ip_redirect ? wr_q : (pop ? ptr_inc(rd_q) : rd_q);
    cnt_d = bus.ip_redirect ? '0 : (cnt_q + CNT_W'(push) - CNT_W'(pop));
    tw_d  = issue ? ptr_inc(tw_q) : tw_q;
    tr_d  = resp ? ptr_inc(tr_q) : tr_q;
  end

  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      run_q  <= 1'b0;
      pc_q   <= RESET_PC;
      out_q  <= '0;
      disc_q <= '0;
      cnt_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      tw_q   <= '0;
      tr_q   <= '0;
    end else begin
      run_q  <= 1'b1;
      pc_q   <= pc_d;
      out_q  <= out_d;
      disc_q <= disc_d;
      cnt_q  <= cnt_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      tw_q   <= tw_d;
      tr_q   <= tr_d;
    end
  end

  // Storage carries no reset; the occupancy count decides what is meaningful.
  always_ff @(posedge ip_clk) begin
    if (issue)
      tag_mem[tw_q] <= pc_q;
    if (push) begin
      instr_mem[wr_q] <= bus.ip_imem_rdata;
      ipc_mem[wr_q]   <= tag_mem[tr_q];
    end
  end

  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n)
      state_q <= ST_FETCH;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.ip_redirect) begin
      if (bus.ip_redirect_addr[1:0] != 2'b00)
        state_d = ST_HALT;
      else if (out_d != '0)
        state_d = ST_DISCARD;
      else
        state_d = ST_FETCH;
    end else if ((state_q == ST_DISCARD) && (disc_d == '0)) begin
      state_d = ST_FETCH;
    end
  end

  always_comb begin
    req        = 1'b0;
    misaligned = 1'b0;
    case (state_q)
      ST_FETCH: req        = run_q & room;
      ST_HALT:  misaligned = 1'b1;
      default:  req        = 1'b0;
    endcase
  end

  assign bus.op_imem_req    = req;
  assign bus.op_imem_addr   = pc_q;
  assign bus.op_misaligned  = misaligned;
  assign bus.op_instr_valid = head_vld & ~bus.ip_redirect;
  assign bus.op_instr       = head_vld ? instr_mem[rd_q] : 32'h0;
  assign bus.op_instr_pc    = head_vld ? ipc_mem[rd_q] : 32'h0;

endmodule
